s27_scan_ctrl: RTL and testbench

//  Scan-test sequencer that sits directly upstream of the scan-inserted s27 core.
//  Per pattern it drives the core's scan/test pins (SE, SI, G0..G3): shift-in, one capture, shift-out.
//  It collects the scan-out response and the captured primary output.
//  It compares both against expected values and keeps saturating pass/fail counts.
//  It replaces hand-written SE/SI stimulus in benches and on-chip BIST wrappers.

---
 rtl/s27_scan_ctrl.sv | 159 +++++++++++++++
 tb/tb_s27_scan_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/s27_scan_ctrl.sv
// Scan-test sequencer for the scan-inserted s27 core: per pattern it shifts in,
// pulses one capture, shifts out, and scores the response against expectations.
module s27_scan_ctrl #(
  parameter int CHAIN_LEN = 3,
  parameter int PI_W      = 4,
  parameter int PO_W      = 1,
  parameter int CNT_W     = 8
) (
  input  logic                 CK,
  input  logic                 RST,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] pat_si,
  input  logic [PI_W-1:0]      pat_pi,
  input  logic [CHAIN_LEN-1:0] exp_so,
  input  logic [PO_W-1:0]      exp_po,
  input  logic                 SO,
  input  logic [PO_W-1:0]      PO,
  output logic                 SE,
  output logic                 SI,
  output logic [PI_W-1:0]      PI,
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] resp,
  output logic [PO_W-1:0]      po_cap,
  output logic                 mismatch,
  output logic [CNT_W-1:0]     pass_cnt,
  output logic [CNT_W-1:0]     fail_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CAPT,
    S_UNLOAD,
    S_DONE
  } state_t;

  localparam int                BIT_W    = $clog2(CHAIN_LEN);
  localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  state_t                 r_state;
  logic [BIT_W-1:0]       r_bit;
  logic [CHAIN_LEN-1:0]   r_shift;
  logic [CHAIN_LEN-1:0]   r_exp_so;
  logic [PO_W-1:0]        r_exp_po;
  logic                   r_se;
  logic                   r_si;
  logic [PI_W-1:0]        r_pi;
  logic                   r_busy;
  logic                   r_done;
  logic [CHAIN_LEN-1:0]   r_resp;
  logic [PO_W-1:0]        r_po_cap;
  logic                   r_mismatch;
  logic [CNT_W-1:0]       r_pass_cnt;
  logic [CNT_W-1:0]       r_fail_cnt;

  logic [CHAIN_LEN-1:0]   w_resp_next;
  logic                   w_mismatch;

  // The verdict on the last unload edge must see the bit arriving on that same edge.
  assign w_resp_next = {r_resp[CHAIN_LEN-2:0], SO};
  assign w_mismatch  = (w_resp_next != r_exp_so) || (r_po_cap != r_exp_po);

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples pre-edge values, exactly as the core does.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_bit      <= '0;
      r_shift    <= '0;
      r_exp_so   <= '0;
      r_exp_po   <= '0;
      r_se       <= 1'b0;
      r_si       <= 1'b0;
      r_pi       <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_resp     <= '0;
      r_po_cap   <= '0;
      r_mismatch <= 1'b0;
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_shift    <= pat_si;
            r_exp_so   <= exp_so;
            r_exp_po   <= exp_po;
            r_pi       <= pat_pi;
            r_se       <= 1'b1;
            r_si       <= pat_si[CHAIN_LEN-1];
            r_busy     <= 1'b1;
            r_resp     <= '0;
            r_mismatch <= 1'b0;
            r_bit      <= '0;
            r_state    <= S_LOAD;
          end else begin
            r_state <= S_IDLE;
          end
        end

        S_LOAD: begin
          if (r_bit == LAST_BIT) begin
            r_se    <= 1'b0;
            r_si    <= 1'b0;
            r_state <= S_CAPT;
          end else begin
            // r_shift walks left so its second-from-top bit is always the next SI.
            r_si    <= r_shift[CHAIN_LEN-2];
            r_shift <= r_shift << 1;
            r_bit   <= r_bit + 1'b1;
          end
        end

        S_CAPT: begin
          r_po_cap <= PO;
          r_se     <= 1'b1;
          r_bit    <= '0;
          r_state  <= S_UNLOAD;
        end

        S_UNLOAD: begin
          r_resp <= w_resp_next;
          if (r_bit == LAST_BIT) begin
            r_se       <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_mismatch <= w_mismatch;
            if (w_mismatch) begin
              if (r_fail_cnt != CNT_MAX) r_fail_cnt <= r_fail_cnt + 1'b1;
            end else begin
              if (r_pass_cnt != CNT_MAX) r_pass_cnt <= r_pass_cnt + 1'b1;
            end
            r_state <= S_DONE;
          end else begin
            r_bit <= r_bit + 1'b1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign SE       = r_se;
  assign SI       = r_si;
  assign PI       = r_pi;
  assign busy     = r_busy;
  assign done     = r_done;
  assign resp     = r_resp;
  assign po_cap   = r_po_cap;
  assign mismatch = r_mismatch;
  assign pass_cnt = r_pass_cnt;
  assign fail_cnt = r_fail_cnt;

endmodule

// File: tb/tb_s27_scan_ctrl.sv
// Bench for s27_scan_ctrl: behavioural 3-flop s27 chain as the plant, a
// transaction-level reference model, and a per-cycle compare process.
module tb_s27_scan_ctrl;

  localparam int N     = 3;
  localparam int PI_W  = 4;
  localparam int PO_W  = 1;
  localparam int CNT_W = 8;
  localparam int T_PAT = 2 * N + 1;   // edges from accept to done

  logic            CK = 1'b0;
  logic            RST;
  logic            start;
  logic [N-1:0]    pat_si;
  logic [PI_W-1:0] pat_pi;
  logic [N-1:0]    exp_so;
  logic [PO_W-1:0] exp_po;

  logic            SO, SE, SI, busy, done, mismatch;
  logic [PO_W-1:0] PO, po_cap;
  logic [PI_W-1:0] PI;
  logic [N-1:0]    resp;
  logic [CNT_W-1:0] pass_cnt, fail_cnt;

  logic            SO2, SE2, SI2, busy2, done2, mismatch2;
  logic [PO_W-1:0] PO2, po_cap2;
  logic [PI_W-1:0] PI2;
  logic [N-1:0]    resp2;
  logic [1:0]      pass_cnt2, fail_cnt2;

  s27_scan_ctrl #(.CHAIN_LEN(N), .PI_W(PI_W), .PO_W(PO_W), .CNT_W(CNT_W)) dut (
    .CK(CK), .RST(RST), .start(start), .pat_si(pat_si), .pat_pi(pat_pi),
    .exp_so(exp_so), .exp_po(exp_po), .SO(SO), .PO(PO), .SE(SE), .SI(SI),
    .PI(PI), .busy(busy), .done(done), .resp(resp), .po_cap(po_cap),
    .mismatch(mismatch), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
  );

  s27_scan_ctrl #(.CHAIN_LEN(N), .PI_W(PI_W), .PO_W(PO_W), .CNT_W(2)) dut_sat (
    .CK(CK), .RST(RST), .start(start), .pat_si(pat_si), .pat_pi(pat_pi),
    .exp_so(exp_so), .exp_po(exp_po), .SO(SO2), .PO(PO2), .SE(SE2), .SI(SI2),
    .PI(PI2), .busy(busy2), .done(done2), .resp(resp2), .po_cap(po_cap2),
    .mismatch(mismatch2), .pass_cnt(pass_cnt2), .fail_cnt(fail_cnt2)
  );

  always #5 CK = ~CK;

  // s27 plant: shift when SE, otherwise capture ~q; PO = q[0]^PI[0].
  logic [N-1:0] q  = '0;
  logic [N-1:0] q2 = '0;
  always @(posedge CK) q  <= SE  ? {q[N-2:0], SI}   : ~q;
  always @(posedge CK) q2 <= SE2 ? {q2[N-2:0], SI2} : ~q2;
  assign SO  = q[N-1];
  assign PO  = q[0] ^ PI[0];
  assign SO2 = q2[N-1];
  assign PO2 = q2[0] ^ PI2[0];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a pattern is a transaction; m_c counts edges since accept.
  bit           m_active = 1'b0;
  int           m_c      = 0;
  logic [N-1:0] m_si     = '0;
  logic [PI_W-1:0] m_pi  = '0;
  logic [N-1:0] m_exp_so = '0;
  logic         m_exp_po = 1'b0;
  logic [N-1:0] m_resp   = '0;
  logic         m_po     = 1'b0;
  bit           m_mis    = 1'b0;
  int           m_pass   = 0;
  int           m_fail   = 0;

  always @(posedge CK or posedge RST) begin
    if (RST) begin
      m_active = 1'b0;
      m_c      = 0;
      m_pi     = '0;
      m_pass   = 0;
      m_fail   = 0;
    end else if ((!m_active || m_c == T_PAT) && start) begin
      m_active = 1'b1;
      m_c      = 0;
      m_si     = pat_si;
      m_pi     = pat_pi;
      m_exp_so = exp_so;
      m_exp_po = exp_po[0];
    end else if (m_active) begin
      m_c++;
      if (m_c == T_PAT) begin
        // Loaded q equals pat_si; capture inverts it; PO is seen before capture.
        m_resp = ~m_si;
        m_po   = m_si[0] ^ m_pi[0];
        m_mis  = (m_resp != m_exp_so) || (m_po != m_exp_po);
        if (m_mis) m_fail++; else m_pass++;
      end else if (m_c > T_PAT) begin
        m_active = 1'b0;
      end
    end
  end

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  bit chk_en = 1'b0;

  always @(negedge CK) begin
    if (chk_en && !RST) begin
      logic e_se, e_si, e_busy, e_done;
      e_se   = m_active && (m_c < N || (m_c > N && m_c <= 2 * N));
      e_si   = (m_active && m_c < N) ? m_si[N-1-m_c] : 1'b0;
      e_busy = m_active && m_c <= 2 * N;
      e_done = m_active && m_c == T_PAT;
      check("SE", 32'(SE), 32'(e_se));
      check("SI", 32'(SI), 32'(e_si));
      check("PI", 32'(PI), 32'(m_pi));
      check("busy", 32'(busy), 32'(e_busy));
      check("done", 32'(done), 32'(e_done));
      check("pass_cnt", 32'(pass_cnt), sat(m_pass, 255));
      check("fail_cnt", 32'(fail_cnt), sat(m_fail, 255));
      check("sat.busy", 32'(busy2), 32'(e_busy));
      check("sat.done", 32'(done2), 32'(e_done));
      check("sat.pass_cnt", 32'(pass_cnt2), sat(m_pass, 3));
      check("sat.fail_cnt", 32'(fail_cnt2), sat(m_fail, 3));
      if (e_done) begin
        check("resp", 32'(resp), 32'(m_resp));
        check("po_cap", 32'(po_cap), 32'(m_po));
        check("mismatch", 32'(mismatch), 32'(m_mis));
        check("sat.mismatch", 32'(mismatch2), 32'(m_mis));
      end
    end
  end

  task automatic drive(input logic s, input logic [N-1:0] si, input logic [PI_W-1:0] pi,
                       input logic [N-1:0] eso, input logic epo);
    @(posedge CK);
    #2;
    start  = s;
    pat_si = si;
    pat_pi = pi;
    exp_so = eso;
    exp_po = epo;
  endtask

  // Returns at the negedge where done is high.
  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 4 * T_PAT && !seen; i++) begin
      @(negedge CK);
      if (done) seen = 1'b1;
    end
    check({name, ".done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic run_pattern(input string name, input logic [N-1:0] si, input logic [PI_W-1:0] pi,
                             input logic [N-1:0] eso, input logic epo);
    drive(1'b1, si, pi, eso, epo);
    drive(1'b0, si, pi, eso, epo);
    wait_done(name);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 4 * T_PAT && (busy || done); i++) @(negedge CK);
    check("idle_reached", 32'(busy || done), 32'd0);
  endtask

  int done_at[$];

  initial begin
    RST    = 1'b1;
    start  = 1'b0;
    pat_si = '0;
    pat_pi = '0;
    exp_so = '0;
    exp_po = '0;
    repeat (2) @(negedge CK);
    check("rst.SE", 32'(SE), 0);
    check("rst.busy", 32'(busy), 0);
    check("rst.resp", 32'(resp), 0);
    check("rst.pass_cnt", 32'(pass_cnt), 0);
    @(posedge CK);
    #2 RST = 1'b0;
    chk_en = 1'b1;

    // 101 / PI 0101: resp 010, po_cap 0 -> pass.
    run_pattern("pat_pass", 3'b101, 4'b0101, 3'b010, 1'b0);
    check("lit.resp", 32'(resp), 32'b010);
    check("lit.po_cap", 32'(po_cap), 0);
    check("lit.mismatch", 32'(mismatch), 0);
    check("lit.pass_cnt", 32'(pass_cnt), 1);

    run_pattern("pat_fail", 3'b101, 4'b0101, 3'b011, 1'b0);
    check("lit.mismatch_fail", 32'(mismatch), 1);
    check("lit.fail_cnt", 32'(fail_cnt), 1);
    check("lit.pass_cnt_hold", 32'(pass_cnt), 1);

    // Async reset in the middle of LOAD.
    drive(1'b1, 3'b011, 4'b1111, 3'b100, 1'b0);
    drive(1'b0, 3'b011, 4'b1111, 3'b100, 1'b0);
    @(posedge CK);
    #3 RST = 1'b1;
    #1;
    check("arst.SE", 32'(SE), 0);
    check("arst.SI", 32'(SI), 0);
    check("arst.busy", 32'(busy), 0);
    check("arst.pass_cnt", 32'(pass_cnt), 0);
    check("arst.fail_cnt", 32'(fail_cnt), 0);
    @(posedge CK);
    #2 RST = 1'b0;
    // 110 / PI 0011: resp 001, po_cap = 0^1 = 1.
    run_pattern("post_rst", 3'b110, 4'b0011, 3'b001, 1'b1);
    check("lit.post_rst_mis", 32'(mismatch), 0);
    check("lit.post_rst_pass", 32'(pass_cnt), 1);

    // start held high: back-to-back patterns, done every 2N+2 edges.
    wait_idle();
    drive(1'b1, 3'b100, 4'b0001, 3'b011, 1'b1);
    for (int i = 0; i < 40 && done_at.size() < 3; i++) begin
      @(negedge CK);
      if (done) done_at.push_back(i);
    end
    check("b2b.pulses", 32'(done_at.size()), 3);
    if (done_at.size() == 3) begin
      check("b2b.gap1", 32'(done_at[1] - done_at[0]), 32'(T_PAT + 1));
      check("b2b.gap2", 32'(done_at[2] - done_at[1]), 32'(T_PAT + 1));
    end
    drive(1'b0, 3'b100, 4'b0001, 3'b011, 1'b1);
    wait_idle();

    // start pulsed during UNLOAD with another pattern: must be ignored.
    drive(1'b1, 3'b001, 4'b0110, 3'b110, 1'b1);
    drive(1'b0, 3'b001, 4'b0110, 3'b110, 1'b1);
    repeat (N) drive(1'b0, 3'b001, 4'b0110, 3'b110, 1'b1);
    drive(1'b1, 3'b111, 4'b1001, 3'b000, 1'b0);
    drive(1'b0, 3'b111, 4'b1001, 3'b000, 1'b0);
    wait_done("ignore");
    check("lit.ignore_resp", 32'(resp), 32'b110);
    check("lit.ignore_PI", 32'(PI), 32'b0110);
    check("lit.ignore_mis", 32'(mismatch), 0);

    // Five more passing patterns: the 2-bit counter saturates at 3.
    for (int k = 0; k < 5; k++) begin
      logic [N-1:0] s;
      logic [PI_W-1:0] p;
      s = N'($urandom);
      p = PI_W'($urandom);
      run_pattern("sat_run", s, p, ~s, s[0] ^ p[0]);
    end
    check("lit.sat_pass", 32'(pass_cnt2), 3);

    // Randomised traffic: random start, random patterns, half with correct expectations.
    for (int k = 0; k < 400; k++) begin
      logic [N-1:0] s, e;
      logic [PI_W-1:0] p;
      logic ep;
      s  = N'($urandom);
      p  = PI_W'($urandom);
      e  = ($urandom_range(1, 0) == 1) ? ~s : N'($urandom);
      ep = ($urandom_range(1, 0) == 1) ? (s[0] ^ p[0]) : 1'($urandom);
      drive(($urandom_range(2, 0) == 0), s, p, e, ep);
    end
    drive(1'b0, '0, '0, '0, 1'b0);
    wait_idle();
    repeat (2) @(negedge CK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
